// File: rtl/piso_tx_unit.sv
// piso_tx_unit: UART transmit serializer with a valid/ready byte input.
// Each frame is a start bit, the data bits LSB first, an optional parity bit
// and one or two stop bits. The line idles high. Bit timing comes from a
// free-running baud counter that is cleared when a byte is accepted.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, tx_ready high, waiting for tx_valid
// S_START  | start bit (low) for one bit time
// S_DATA   | shift register LSB on the line, bit_count = bit index
// S_PARITY | parity bit for one bit time (only when parity is enabled)
// S_STOP   | line high for STOP_BITS bit times, then back to S_IDLE
module piso_tx_unit #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic [3:0]       bit_count
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
  logic [WIDTH-1:0]  shift_reg, shift_reg_n;
  logic              parity_bit, parity_bit_n;
  logic              stop_cnt, stop_cnt_n;
  logic              tx_n;
  logic              tx_ready_n;
  logic [3:0]        bit_count_n;
  logic              bit_tick;

  // bit boundary: the baud counter is about to wrap
  assign bit_tick = (baud_cnt == BAUD_LAST);

  // state and all outputs are registered so tx only moves on clock edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_ready   <= 1'b1;
      bit_count  <= 4'd0;
    end else begin
      state      <= state_n;
      baud_cnt   <= baud_cnt_n;
      shift_reg  <= shift_reg_n;
      parity_bit <= parity_bit_n;
      stop_cnt   <= stop_cnt_n;
      tx         <= tx_n;
      tx_ready   <= tx_ready_n;
      bit_count  <= bit_count_n;
    end
  end

  // next-state and next-output decode; every transition lands on a bit tick
  always_comb begin
    state_n      = state;
    baud_cnt_n   = bit_tick ? '0 : baud_cnt + BAUD_W'(1);
    shift_reg_n  = shift_reg;
    parity_bit_n = parity_bit;
    stop_cnt_n   = stop_cnt;
    tx_n         = tx;
    tx_ready_n   = tx_ready;
    bit_count_n  = bit_count;

    case (state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_n      = S_START;
          baud_cnt_n   = '0;
          shift_reg_n  = tx_data;
          parity_bit_n = (^tx_data) ^ (PARITY_ODD != 0);
          tx_n         = 1'b0;
          tx_ready_n   = 1'b0;
          bit_count_n  = 4'd0;
        end
      end

      S_START: begin
        if (bit_tick) begin
          state_n     = S_DATA;
          tx_n        = shift_reg[0];
          bit_count_n = 4'd0;
        end
      end

      S_DATA: begin
        if (bit_tick) begin
          if (bit_count == BIT_LAST) begin
            bit_count_n = 4'd0;
            stop_cnt_n  = 1'b0;
            if (PARITY_EN != 0) begin
              state_n = S_PARITY;
              tx_n    = parity_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            shift_reg_n = shift_reg >> 1;
            tx_n        = shift_reg[1];
            bit_count_n = bit_count + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (bit_tick) begin
          state_n    = S_STOP;
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_n    = S_IDLE;
            tx_ready_n = 1'b1;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n    = S_IDLE;
        tx_n       = 1'b1;
        tx_ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx_unit.sv
// Bench for piso_tx_unit: three instances (plain 8N1, 8E1, 7O2) driven by
// directed frames and random frames, each compared cycle by cycle with a
// frame bit list built from the framing rules.
module tb_piso_tx_unit;

  localparam int C = 16;

  logic       clk;
  logic       reset;
  logic [7:0] txd_a, txd_b;
  logic [6:0] txd_c;
  logic       vld   [3];
  logic       tx_o  [3];
  logic       rdy   [3];
  logic [3:0] bc    [3];

  int  n_cmp = 0;
  int  n_err = 0;
  time t1, t2;

  piso_tx_unit #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(txd_a), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(tx_o[0]), .bit_count(bc[0]));

  piso_tx_unit #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .reset(reset), .tx_data(txd_b), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(tx_o[1]), .bit_count(bc[1]));

  piso_tx_unit #(.WIDTH(7), .CLKS_PER_BIT(C), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_c (
    .clk(clk), .reset(reset), .tx_data(txd_c), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(tx_o[2]), .bit_count(bc[2]));

  // free-running clock, posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard stop in case something never returns
  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  function automatic int wid(int d);
    return (d == 2) ? 7 : 8;
  endfunction

  function automatic bit pe(int d);
    return d != 0;
  endfunction

  function automatic bit po(int d);
    return d == 2;
  endfunction

  function automatic int sb(int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(int d, logic [7:0] v);
    case (d)
      0:       txd_a = v;
      1:       txd_b = v;
      default: txd_c = v[6:0];
    endcase
  endtask

  // Offer one byte and follow the whole frame. Entered in the low clock
  // phase; returns at the falling edge after the frame's last bit edge.
  task automatic send_frame(int d, logic [7:0] data, bit hold, int chg,
                            logic [7:0] alt, output time t_acc);
    logic       bits [$];
    logic       p;
    int         n, guard, idx;
    logic [3:0] exp_bc;
    p = po(d);
    bits.push_back(1'b0);
    for (int i = 0; i < wid(d); i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    if (pe(d)) bits.push_back(p);
    for (int i = 0; i < sb(d); i++) bits.push_back(1'b1);
    n = bits.size();

    set_data(d, data);
    vld[d] = 1'b1;
    guard = 0;
    while (rdy[d] !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("accept_ready d%0d", d), rdy[d], 1);
    if (rdy[d] !== 1'b1) begin
      vld[d] = 1'b0;
      t_acc  = 0;
      return;
    end
    @(posedge clk);
    t_acc = $time;
    for (int j = 0; j < n * C; j++) begin
      @(negedge clk);
      idx    = j / C;
      exp_bc = (idx >= 1 && idx <= wid(d)) ? 4'(idx - 1) : 4'd0;
      chk($sformatf("tx d%0d j%0d", d, j), tx_o[d], bits[idx]);
      chk($sformatf("ready d%0d j%0d", d, j), rdy[d], 0);
      chk($sformatf("bit_count d%0d j%0d", d, j), bc[d], exp_bc);
      if (j == 0 && !hold) vld[d] = 1'b0;
      if (j == chg) set_data(d, alt);
    end
    @(negedge clk);
    chk($sformatf("end_tx d%0d", d), tx_o[d], 1);
    chk($sformatf("end_ready d%0d", d), rdy[d], 1);
    chk($sformatf("end_bit_count d%0d", d), bc[d], 0);
  endtask

  initial begin
    logic [7:0] rd, ra;
    int         rdut, rchg, rgap;

    // reset held with valid high: idle outputs, nothing accepted
    reset = 1'b1;
    txd_a = 8'h5A;
    txd_b = 8'hC3;
    txd_c = 7'h2B;
    for (int d = 0; d < 3; d++) vld[d] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rst_tx d%0d", d), tx_o[d], 1);
        chk($sformatf("rst_ready d%0d", d), rdy[d], 1);
        chk($sformatf("rst_bit_count d%0d", d), bc[d], 0);
      end
    end
    for (int d = 0; d < 3; d++) vld[d] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_tx d%0d", d), tx_o[d], 1);
      chk($sformatf("post_rst_ready d%0d", d), rdy[d], 1);
    end

    // directed frames
    send_frame(0, 8'hA5, 1'b0, -1, 8'h00, t1);
    send_frame(1, 8'h07, 1'b0, -1, 8'h00, t1);
    send_frame(2, 8'h07, 1'b0, -1, 8'h00, t1);

    // back-to-back with valid held: start edges C*N+1 cycles apart
    send_frame(0, 8'h00, 1'b1, -1, 8'h00, t1);
    send_frame(0, 8'hFF, 1'b0, -1, 8'h00, t2);
    chk("b2b_spacing_ns", 32'(t2 - t1), (10 * C + 1) * 10);

    // data input changed during data bit 2 must not reach the line
    send_frame(0, 8'h81, 1'b0, 3 * C + 4, 8'h7E, t1);

    // reset during data bit 3 of 0x55 aborts the frame immediately
    set_data(0, 8'h55);
    vld[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (4 * C + 6) @(negedge clk);
    chk("abort_pre_tx", tx_o[0], 0);
    chk("abort_pre_bit_count", bc[0], 3);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx", tx_o[0], 1);
    chk("abort_ready", rdy[0], 1);
    chk("abort_bit_count", bc[0], 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_release_ready", rdy[0], 1);
    chk("abort_release_tx", tx_o[0], 1);
    send_frame(0, 8'h3C, 1'b0, -1, 8'h00, t1);

    // random frames, random mid-frame data changes and idle gaps
    for (int k = 0; k < 12; k++) begin
      rdut = $urandom_range(0, 2);
      rd   = 8'($urandom);
      ra   = 8'($urandom);
      if (rdut == 2) begin
        rd = rd & 8'h7F;
        ra = ra & 8'h7F;
      end
      rchg = $urandom_range(1, 9 * C);
      send_frame(rdut, rd, 1'b0, rchg, ra, t1);
      rgap = $urandom_range(0, 3);
      repeat (rgap) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx_unit.md
# piso_tx_unit

UART transmit stage that serializes a parallel byte onto the serial line, producing the start/data/parity/stop frames consumed by the receive-side shift register unit. It takes bytes through a valid/ready handshake and generates its own bit timing from a clock-cycle counter. Data is sent LSB first and the line idles high. It sits between the host-side byte source and the `tx` pin (or the receiver in loopback benches).

## Interface
- `WIDTH`, 8: data bits per frame; supported range 5–9.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 gives even parity, 1 gives odd parity; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_data`  in  WIDTH  byte to send; sampled only on acceptance.
- `tx_valid`  in  1  source has a byte.
- `tx_ready`  out  1  unit can accept a byte (high only in IDLE).
- `tx`  out  1  serial line, registered; idles high.
- `bit_count`  out  4  index of the data bit being driven in DATA; 0 otherwise.

## Operation
- Reset (async, immediate): `tx`=1, `tx_ready`=1, `bit_count`=0, state IDLE, baud counter 0, shift register 0.
- FSM states:
  - IDLE → START on `tx_valid && tx_ready` at a posedge ("acceptance"). On that edge:
    - latch `tx_data` into the shift register;
    - compute the parity bit: XOR of the data, inverted if `PARITY_ODD`;
    - clear the baud counter;
    - set `tx`=0 and `tx_ready`=0.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then → DATA.
  - DATA: `tx`=shift register[0]. Every `CLKS_PER_BIT` cycles, shift right and increment `bit_count`. After `WIDTH` bits → PARITY if `PARITY_EN`, else → STOP.
  - PARITY: `tx`=parity bit for `CLKS_PER_BIT` cycles, then → STOP.
  - STOP: `tx`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then → IDLE with `tx_ready`=1.
- Baud counter: counts 0..`CLKS_PER_BIT`−1 and wraps at each bit boundary; it is cleared only on acceptance and reset. Width is $clog2(`CLKS_PER_BIT`).
- `tx_data`/`tx_valid` changes outside acceptance are ignored; the frame in flight is never altered.
- `tx_valid` dropping mid-frame has no effect.
- `tx` changes only on bit boundaries and is glitch-free (register output).
- Reset asserted mid-frame aborts the frame: `tx` goes high asynchronously and nothing is resumed after release.

## Timing
- Let acceptance occur at edge k, C = `CLKS_PER_BIT`, and N = 1 + `WIDTH` + `PARITY_EN` + `STOP_BITS`.
- `tx` falls at edge k (latency 0 cycles after the accepting edge; the value is visible in cycle k+1).
- Data bit i is driven from edge k+C·(1+i) to edge k+C·(2+i).
- The parity bit (if enabled) starts at edge k+C·(1+`WIDTH`).
- STOP ends and `tx_ready` rises at edge k+C·N.
- Earliest next acceptance is edge k+C·N+1. With `tx_valid` held high, start-bit falling edges are exactly C·N+1 cycles apart, including one idle-high cycle between frames.
- `bit_count` updates on the same edges as `tx`. It is 0 during START, PARITY, STOP and IDLE.

## Test plan
- Reset values: assert `reset` with `tx_valid`=1 → `tx`=1, `tx_ready`=1, `bit_count`=0 throughout reset, and no acceptance occurs.
- Single frame, C=16, no parity, `tx_data`=0xA5 → `tx` low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 16 cycles high. `tx_ready` rises at acceptance+160.
- Parity, even, `tx_data`=0x07 → parity bit 1 at acceptance+144..159, stop ends at +176. Same frame with `PARITY_ODD`=1 → parity bit 0.
- Back-to-back: send 0x00 then 0xFF with `tx_valid` held high → falling start edges 161 cycles apart, with exactly one idle-high cycle between the stop bit and the second start bit.
- Mid-frame abort: assert `reset` during data bit 3 of 0x55 → `tx`=1 in the same cycle. After release, `tx_ready`=1, and a new 0x3C frame is transmitted correctly.
- Input stability: change `tx_data` from 0x81 to 0x7E during data bit 2 → the line still carries 0x81; `STOP_BITS`=2 → stop lasts 32 cycles.
